// File: rtl/logic_gate_acc.sv
// logic_gate_acc: bitwise logic reduction across NUM_IN lanes of WIDTH bits,
// behind a valid/ready stream with a registered output. Accumulate mode folds
// a multi-beat packet into one result word using the op latched on its first
// beat.
// Optional feature: define LOGIC_GATE_ACC_BEATCNT_EN to add the 16-bit
// saturating out_beats output (number of beats folded into the result).
module logic_gate_acc #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              in_op,
    input  logic                    in_acc,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
    output logic [15:0]             out_beats,
`endif
    output logic                    out_err
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    // Registered state
    state_t             state_q,     state_d;
    op_t                op_q,        op_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic               out_err_q,   out_err_d;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
    logic [15:0]        cnt_q,       cnt_d;
    logic [15:0]        beats_q,     beats_d;
    logic [15:0]        cnt_inc;
`endif

    // Combinational datapath
    logic [WIDTH-1:0]   red_and, red_or, red_xor;
    op_t                eff_op;
    logic [WIDTH-1:0]   beat_base;
    logic [WIDTH-1:0]   merged;
    logic [WIDTH-1:0]   result;
    logic               result_err;
    logic               accept;

    // A new beat may enter whenever the output slot is empty or being drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Fold each base operator across all lanes of the current beat.
    // NOTE: blocking assignments are correct inside always_comb; the running
    // fold must see its own updated value on each loop iteration.
    always_comb begin
        red_and = in_data[WIDTH-1:0];
        red_or  = in_data[WIDTH-1:0];
        red_xor = in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            red_and = red_and & in_data[k*WIDTH +: WIDTH];
            red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
            red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
        end
    end

    // Select the base reduction, merge with the accumulator mid-packet and
    // apply the output inversion for the negated ops.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is
        // inferred for unlisted op encodings.
        eff_op     = (state_q == ACCUM) ? op_q : op_t'(in_op);
        beat_base  = '0;
        merged     = '0;
        result_err = (eff_op == OP_RSVD);

        case (eff_op)
            OP_AND, OP_NAND: beat_base = red_and;
            OP_OR,  OP_NOR:  beat_base = red_or;
            OP_XOR, OP_XNOR: beat_base = red_xor;
            OP_PASS:         beat_base = in_data[WIDTH-1:0];
            default:         beat_base = '0;
        endcase

        merged = beat_base;
        if (state_q == ACCUM) begin
            case (eff_op)
                OP_AND, OP_NAND: merged = acc_q & beat_base;
                OP_OR,  OP_NOR:  merged = acc_q | beat_base;
                OP_XOR, OP_XNOR: merged = acc_q ^ beat_base;
                default:         merged = beat_base;
            endcase
        end

        case (eff_op)
            OP_NAND, OP_NOR, OP_XNOR: result = ~merged;
            default:                  result = merged;
        endcase
    end

`ifdef LOGIC_GATE_ACC_BEATCNT_EN
    // Saturating increment of the in-packet beat count.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif

    // Next-state logic for the IDLE/ACCUM packet FSM and the output register.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
        cnt_d       = cnt_q;
        beats_d     = beats_q;
`endif

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!in_acc || in_last) begin
                        out_valid_d = 1'b1;
                        out_data_d  = result;
                        out_err_d   = result_err;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
                        beats_d     = 16'd1;
`endif
                    end else begin
                        op_d    = op_t'(in_op);
                        acc_d   = beat_base;
                        state_d = ACCUM;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
                        cnt_d   = 16'd1;
`endif
                    end
                end
                ACCUM: begin
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_data_d  = result;
                        out_err_d   = result_err;
                        acc_d       = '0;
                        state_d     = IDLE;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
                        beats_d     = cnt_inc;
                        cnt_d       = '0;
`endif
                    end else begin
                        acc_d = merged;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
                        cnt_d = cnt_inc;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all flops so every register
        // samples its pre-edge _d value regardless of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_AND;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
            cnt_q       <= '0;
            beats_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
            cnt_q       <= cnt_d;
            beats_q     <= beats_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
    assign out_beats = beats_q;
`endif

endmodule

// File: tb/tb_logic_gate_acc.sv
// Self-checking bench for logic_gate_acc: an 8-bit two-lane instance for the
// op table, accumulate, backpressure and reset cases, plus a 1-bit two-lane
// instance for the basic AND truth table.
module tb_logic_gate_acc;

    logic        clk;
    logic        rst_n;

    // WIDTH=8, NUM_IN=2 instance
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_op;
    logic        in_acc;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_err;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
    logic [15:0] out_beats;
`endif

    // WIDTH=1, NUM_IN=2 instance
    logic        t1_in_valid;
    logic        t1_in_ready;
    logic [1:0]  t1_in_data;
    logic        t1_out_valid;
    logic [0:0]  t1_out_data;
    logic        t1_out_err;
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
    logic [15:0] t1_out_beats;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] lane0;
        logic [7:0] lane1;
        logic [2:0] op;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    typedef struct {
        logic [1:0] ab;
        logic       exp;
    } tt_t;

    tt_t tt [4];

    logic_gate_acc #(.WIDTH(8), .NUM_IN(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
        .out_beats (out_beats),
`endif
        .out_err   (out_err)
    );

    logic_gate_acc #(.WIDTH(1), .NUM_IN(2)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (t1_in_valid),
        .in_ready  (t1_in_ready),
        .in_data   (t1_in_data),
        .in_op     (3'd0),
        .in_acc    (1'b0),
        .in_last   (1'b0),
        .out_valid (t1_out_valid),
        .out_ready (1'b1),
        .out_data  (t1_out_data),
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
        .out_beats (t1_out_beats),
`endif
        .out_err   (t1_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat starting at a negedge; returns at the negedge after the
    // accepting posedge with in_valid dropped.
    task automatic send(input logic [7:0] l0, input logic [7:0] l1, input logic [2:0] op,
                        input logic acc, input logic last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = {l1, l0};
        in_op    = op;
        in_acc   = acc;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0};
        vecs[1] = '{8'hF0, 8'h3C, 3'd1, 8'hFC, 1'b0};
        vecs[2] = '{8'hF0, 8'h3C, 3'd2, 8'hCC, 1'b0};
        vecs[3] = '{8'hF0, 8'h3C, 3'd3, 8'hCF, 1'b0};
        vecs[4] = '{8'hF0, 8'h3C, 3'd4, 8'h03, 1'b0};
        vecs[5] = '{8'hF0, 8'h3C, 3'd5, 8'h33, 1'b0};
        vecs[6] = '{8'hF0, 8'h3C, 3'd6, 8'hF0, 1'b0};
        vecs[7] = '{8'hF0, 8'h3C, 3'd7, 8'h00, 1'b1};

        tt[0] = '{2'b00, 1'b0};
        tt[1] = '{2'b01, 1'b0};
        tt[2] = '{2'b10, 1'b0};
        tt[3] = '{2'b11, 1'b1};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_op       = '0;
        in_acc      = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        t1_in_valid = 1'b0;
        t1_in_data  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data",  {24'd0, out_data},  32'd0);
        check("reset_out_err",   {31'd0, out_err},   32'd0);
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1-bit AND truth table, one cycle latency
        for (int i = 0; i < 4; i++) begin
            t1_in_valid = 1'b1;
            t1_in_data  = tt[i].ab;
            @(posedge clk);
            @(negedge clk);
            t1_in_valid = 1'b0;
            check($sformatf("tt%0d_valid", i), {31'd0, t1_out_valid},   32'd1);
            check($sformatf("tt%0d_data", i),  {31'd0, t1_out_data[0]}, {31'd0, tt[i].exp});
        end
        @(negedge clk);
        check("tt_drained", {31'd0, t1_out_valid}, 32'd0);

        // All ops on lanes 0xF0 / 0x3C
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].lane0, vecs[i].lane1, vecs[i].op, 1'b0, 1'b0);
            check($sformatf("op%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("op%0d_data", i),  {24'd0, out_data},  {24'd0, vecs[i].exp_data});
            check($sformatf("op%0d_err", i),   {31'd0, out_err},   {31'd0, vecs[i].exp_err});
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
            check($sformatf("op%0d_beats", i), {16'd0, out_beats}, 32'd1);
`endif
        end
        @(negedge clk);
        check("ops_drained", {31'd0, out_valid}, 32'd0);

        // Accumulate OR packet, op changed to AND mid-packet is ignored
        send(8'h01, 8'h02, 3'd1, 1'b1, 1'b0);
        check("acc_b1_no_valid", {31'd0, out_valid}, 32'd0);
        send(8'h04, 8'h00, 3'd0, 1'b0, 1'b0);
        check("acc_b2_no_valid", {31'd0, out_valid}, 32'd0);
        send(8'h80, 8'h00, 3'd0, 1'b1, 1'b1);
        check("acc_valid", {31'd0, out_valid}, 32'd1);
        check("acc_data",  {24'd0, out_data},  32'h87);
        check("acc_err",   {31'd0, out_err},   32'd0);
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
        check("acc_beats", {16'd0, out_beats}, 32'd3);
`endif

        // Accumulate XNOR packet: (0xF0^0x3C)^(0x0F^0x00) = 0xC3, inverted 0x3C
        send(8'hF0, 8'h3C, 3'd5, 1'b1, 1'b0);
        check("xnor_b1_no_valid", {31'd0, out_valid}, 32'd0);
        send(8'h0F, 8'h00, 3'd1, 1'b1, 1'b1);
        check("xnor_data", {24'd0, out_data}, 32'h3C);

        // Reserved op on first beat flags the whole packet
        send(8'hFF, 8'hFF, 3'd7, 1'b1, 1'b0);
        send(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b1);
        check("rsvd_valid", {31'd0, out_valid}, 32'd1);
        check("rsvd_data",  {24'd0, out_data},  32'h00);
        check("rsvd_err",   {31'd0, out_err},   32'd1);
        @(negedge clk);

        // Backpressure: hold one result for 5 cycles
        out_ready = 1'b0;
        send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i),    {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d_in_ready", i), {31'd0, in_ready},  32'd0);
            check($sformatf("bp%0d_data", i),     {24'd0, out_data},  32'h30);
            @(negedge clk);
        end
        // Same-cycle handoff: release out_ready while a new beat is waiting
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {8'h0F, 8'hFF};
        in_op     = 3'd2;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        #1;
        check("handoff_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("handoff_valid", {31'd0, out_valid}, 32'd1);
        check("handoff_data",  {24'd0, out_data},  32'hF0);
        @(negedge clk);
        check("handoff_drained", {31'd0, out_valid}, 32'd0);

        // Reset in ACCUM after two beats discards the packet
        send(8'h11, 8'h22, 3'd1, 1'b1, 1'b0);
        send(8'h44, 8'h00, 3'd1, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_data",  {24'd0, out_data},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_no_valid", {31'd0, out_valid}, 32'd0);
        send(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b1);
        check("postrst_valid", {31'd0, out_valid}, 32'd1);
        check("postrst_data",  {24'd0, out_data},  32'h0F);
        check("postrst_err",   {31'd0, out_err},   32'd0);
`ifdef LOGIC_GATE_ACC_BEATCNT_EN
        check("postrst_beats", {16'd0, out_beats}, 32'd1);
`endif
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
